// File: rtl/sap_control_sequencer.sv
// Micro-sequencer and instruction register for the 8-bit shared-bus SAP
// datapath. Fetches an opcode off the bus, then steps T-states and decodes
// (t_state, IR, flags) into per-cycle load / output-enable strobes.
//
// Handshake: there is no valid/ready pair here. "run" is a one-way advance
// enable. Every strobe is a pure decode that is held for the whole cycle,
// and its target acts on the rising edge that ends that cycle. When run=0,
// halted=1 or rst=1, all strobes are deasserted and the state holds or resets.
module sap_control_sequencer #(
  parameter int T_MAX = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] bus_in,
  input  logic       cf,
  input  logic       zf,
  output logic [7:0] ir_data,
  output logic [3:0] opcode,
  output logic [2:0] t_state,
  output logic       halted,
  output logic       pc_inc,
  output logic       pc_oe,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_oe,
  output logic       ram_we,
  output logic       ir_oe,
  output logic       a_load,
  output logic       a_oe,
  output logic       b_load,
  output logic       alu_oe_n,
  output logic       alu_sub,
  output logic       out_load
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } t_state_e;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  t_state_e   state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic       halted_q, halted_d;
  logic       advance;
  logic       ir_load;
  logic       last_step;

  assign t_state = state_q;
  assign opcode  = ir_q[7:4];
  assign ir_data = {4'b0000, ir_q[3:0]};
  assign halted  = halted_q;

  // State, IR and halt flag; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= T0;
      ir_q     <= 8'h00;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  // Microcode decode and next T-state; all strobes default to idle.
  always_comb begin
    pc_inc    = 1'b0;
    pc_oe     = 1'b0;
    pc_load   = 1'b0;
    mar_load  = 1'b0;
    ram_oe    = 1'b0;
    ram_we    = 1'b0;
    ir_oe     = 1'b0;
    a_load    = 1'b0;
    a_oe      = 1'b0;
    b_load    = 1'b0;
    alu_oe_n  = 1'b1;
    alu_sub   = 1'b0;
    out_load  = 1'b0;
    ir_load   = 1'b0;
    last_step = 1'b0;
    state_d   = state_q;
    ir_d      = ir_q;
    halted_d  = halted_q;
    advance   = run && !halted_q && !rst;

    if (advance) begin
      case (state_q)
        T0: begin
          pc_oe    = 1'b1;
          mar_load = 1'b1;
        end
        T1: begin
          ram_oe  = 1'b1;
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          case (ir_q[7:4])
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_oe    = 1'b1;
              mar_load = 1'b1;
            end
            OP_LDI: begin
              ir_oe     = 1'b1;
              a_load    = 1'b1;
              last_step = 1'b1;
            end
            OP_JMP: begin
              ir_oe     = 1'b1;
              pc_load   = 1'b1;
              last_step = 1'b1;
            end
            OP_JC: begin
              ir_oe     = cf;
              pc_load   = cf;
              last_step = 1'b1;
            end
            OP_JZ: begin
              ir_oe     = zf;
              pc_load   = zf;
              last_step = 1'b1;
            end
            OP_OUT: begin
              a_oe      = 1'b1;
              out_load  = 1'b1;
              last_step = 1'b1;
            end
            OP_HLT: begin
              halted_d  = 1'b1;
              last_step = 1'b1;
            end
            default: last_step = 1'b1;
          endcase
        end
        T3: begin
          case (ir_q[7:4])
            OP_LDA: begin
              ram_oe    = 1'b1;
              a_load    = 1'b1;
              last_step = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_oe  = 1'b1;
              b_load  = 1'b1;
              alu_sub = (ir_q[7:4] == OP_SUB);
            end
            OP_STA: begin
              a_oe      = 1'b1;
              ram_we    = 1'b1;
              last_step = 1'b1;
            end
            default: last_step = 1'b1;
          endcase
        end
        T4: begin
          if (ir_q[7:4] == OP_ADD || ir_q[7:4] == OP_SUB) begin
            alu_oe_n = 1'b0;
            a_load   = 1'b1;
            alu_sub  = (ir_q[7:4] == OP_SUB);
          end
          last_step = 1'b1;
        end
        default: last_step = 1'b1;
      endcase

      // The final T-state always wraps, whatever the opcode.
      if (int'(state_q) >= T_MAX - 1) last_step = 1'b1;

      if (ir_load) ir_d = bus_in;

      if (last_step) begin
        state_d = T0;
      end else begin
        case (state_q)
          T0:      state_d = T1;
          T1:      state_d = T2;
          T2:      state_d = T3;
          T3:      state_d = T4;
          default: state_d = T0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: instruction-level reference model that
// expands each opcode into its expected list of strobe words, then checks
// the DUT cycle by cycle.
module tb_sap_control_sequencer;

  logic       clk;
  logic       rst;
  logic       run;
  logic [7:0] bus_in;
  logic       cf;
  logic       zf;
  logic [7:0] ir_data;
  logic [3:0] opcode;
  logic [2:0] t_state;
  logic       halted;
  logic       pc_inc, pc_oe, pc_load, mar_load, ram_oe, ram_we, ir_oe;
  logic       a_load, a_oe, b_load, alu_oe_n, alu_sub, out_load;

  int checks = 0;
  int errors = 0;

  // Strobe word: one bit per control, ALU drive shown active-high.
  localparam logic [12:0] PC_INC  = 13'h1000;
  localparam logic [12:0] PC_OE   = 13'h0800;
  localparam logic [12:0] PC_LD   = 13'h0400;
  localparam logic [12:0] MAR_LD  = 13'h0200;
  localparam logic [12:0] RAM_OE  = 13'h0100;
  localparam logic [12:0] RAM_WE  = 13'h0080;
  localparam logic [12:0] IR_OE   = 13'h0040;
  localparam logic [12:0] A_LD    = 13'h0020;
  localparam logic [12:0] A_OE    = 13'h0010;
  localparam logic [12:0] B_LD    = 13'h0008;
  localparam logic [12:0] ALU_EN  = 13'h0004;
  localparam logic [12:0] ALU_SUB = 13'h0002;
  localparam logic [12:0] OUT_LD  = 13'h0001;

  logic [12:0] ctrl;
  assign ctrl = {pc_inc, pc_oe, pc_load, mar_load, ram_oe, ram_we, ir_oe,
                 a_load, a_oe, b_load, ~alu_oe_n, alu_sub, out_load};

  logic [12:0] exp_q[$];

  sap_control_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .bus_in(bus_in), .cf(cf), .zf(zf),
    .ir_data(ir_data), .opcode(opcode), .t_state(t_state), .halted(halted),
    .pc_inc(pc_inc), .pc_oe(pc_oe), .pc_load(pc_load), .mar_load(mar_load),
    .ram_oe(ram_oe), .ram_we(ram_we), .ir_oe(ir_oe), .a_load(a_load),
    .a_oe(a_oe), .b_load(b_load), .alu_oe_n(alu_oe_n), .alu_sub(alu_sub),
    .out_load(out_load)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus contention monitor, every cycle.
  always @(negedge clk) begin
    checks++;
    if ($countones({pc_oe, ram_oe, ir_oe, a_oe, ~alu_oe_n}) > 1) begin
      errors++;
      $display("FAIL bus_drivers: got %b required at most one active t=%0t",
               {pc_oe, ram_oe, ir_oe, a_oe, ~alu_oe_n}, $time);
    end
  end

  // Reference model: instruction length and its per-step strobe list.
  function automatic int n_steps(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  task automatic push_expected(input logic [7:0] instr, input logic c, input logic z);
    logic [3:0] op;
    op = instr[7:4];
    exp_q.push_back(PC_OE | MAR_LD);
    exp_q.push_back(RAM_OE | PC_INC);
    case (op)
      4'h1: begin exp_q.push_back(IR_OE | MAR_LD); exp_q.push_back(RAM_OE | A_LD); end
      4'h2: begin
        exp_q.push_back(IR_OE | MAR_LD); exp_q.push_back(RAM_OE | B_LD);
        exp_q.push_back(ALU_EN | A_LD);
      end
      4'h3: begin
        exp_q.push_back(IR_OE | MAR_LD); exp_q.push_back(RAM_OE | B_LD | ALU_SUB);
        exp_q.push_back(ALU_EN | A_LD | ALU_SUB);
      end
      4'h4: begin exp_q.push_back(IR_OE | MAR_LD); exp_q.push_back(A_OE | RAM_WE); end
      4'h5: exp_q.push_back(IR_OE | A_LD);
      4'h6: exp_q.push_back(IR_OE | PC_LD);
      4'h7: exp_q.push_back(c ? (IR_OE | PC_LD) : 13'h0);
      4'h8: exp_q.push_back(z ? (IR_OE | PC_LD) : 13'h0);
      4'hE: exp_q.push_back(A_OE | OUT_LD);
      default: exp_q.push_back(13'h0);
    endcase
  endtask

  // Driver: runs one instruction from T0, with an optional pause before
  // step pause_at and an optional reset in step abort_at (-1 = none).
  task automatic run_instr(input logic [7:0] instr, input logic c, input logic z,
                           input int pause_at, input int pause_len, input int abort_at);
    int n;
    logic [12:0] exp;
    n = n_steps(instr[7:4]);
    push_expected(instr, c, z);
    for (int k = 0; k < n; k++) begin
      if (k == pause_at) begin
        for (int p = 0; p < pause_len; p++) begin
          run = 1'b0; bus_in = 8'($urandom);
          @(negedge clk);
          checks++;
          if (ctrl !== 13'h0 || t_state !== 3'(k)) begin
            errors++;
            $display("FAIL pause: got ctrl %h t %0d required ctrl 0000 t %0d", ctrl, t_state, k);
          end
          @(posedge clk); #1;
        end
      end
      if (k == abort_at) begin
        rst = 1'b1; run = 1'b1; bus_in = 8'($urandom);
        @(negedge clk);
        checks++;
        if (ctrl !== 13'h0 || alu_oe_n !== 1'b1) begin
          errors++;
          $display("FAIL abort_ctrl: got %h required 0000", ctrl);
        end
        @(posedge clk); #1;
        rst = 1'b0; run = 1'b0;
        @(negedge clk);
        checks++;
        if (t_state !== 3'd0 || opcode !== 4'h0 || ir_data !== 8'h00 ||
            halted !== 1'b0 || alu_oe_n !== 1'b1) begin
          errors++;
          $display("FAIL abort_state: got t %0d op %h ir %h h %b aon %b required 0 0 00 0 1",
                   t_state, opcode, ir_data, halted, alu_oe_n);
        end
        @(posedge clk); #1;
        exp_q.delete();
        return;
      end
      run = 1'b1; cf = c; zf = z;
      bus_in = (k == 1) ? instr : 8'($urandom);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (ctrl !== exp || t_state !== 3'(k)) begin
        errors++;
        $display("FAIL step instr %h T%0d: got ctrl %h t %0d required ctrl %h t %0d",
                 instr, k, ctrl, t_state, exp, k);
      end
      if (k >= 2) begin
        checks++;
        if (opcode !== instr[7:4] || ir_data !== {4'h0, instr[3:0]}) begin
          errors++;
          $display("FAIL ir instr %h: got op %h ir_data %h required op %h ir_data %h",
                   instr, opcode, ir_data, instr[7:4], {4'h0, instr[3:0]});
        end
      end
      @(posedge clk); #1;
    end
    run = 1'b0;
    @(negedge clk);
    checks++;
    if (t_state !== 3'd0 || halted !== (instr[7:4] == 4'hF)) begin
      errors++;
      $display("FAIL end instr %h: got t %0d halted %b required t 0 halted %b",
               instr, t_state, halted, instr[7:4] == 4'hF);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; run = 1'b1; bus_in = 8'hFF; cf = 1'b1; zf = 1'b1;
    @(negedge clk);
    checks++;
    if (ctrl !== 13'h0 || alu_oe_n !== 1'b1 || alu_sub !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h required 0000", ctrl);
    end
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0;
    @(negedge clk);
    checks++;
    if (t_state !== 3'd0 || opcode !== 4'h0 || ir_data !== 8'h00 || halted !== 1'b0 ||
        ctrl !== 13'h0) begin
      errors++;
      $display("FAIL reset_state: got t %0d op %h ir %h h %b ctrl %h required zeros",
               t_state, opcode, ir_data, halted, ctrl);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_nop;
    run_instr(8'h00, 1'b0, 1'b0, -1, 0, -1);
    run_instr(8'h9A, 1'b1, 1'b1, -1, 0, -1);
  endtask

  task automatic test_add_sub;
    run_instr(8'h2E, 1'b0, 1'b0, -1, 0, -1);
    run_instr(8'h3E, 1'b1, 1'b0, -1, 0, -1);
  endtask

  task automatic test_jumps;
    run_instr(8'h75, 1'b1, 1'b0, -1, 0, -1);
    run_instr(8'h75, 1'b0, 1'b1, -1, 0, -1);
    run_instr(8'h83, 1'b0, 1'b1, -1, 0, -1);
    run_instr(8'h83, 1'b1, 1'b0, -1, 0, -1);
    run_instr(8'h6C, 1'b0, 1'b0, -1, 0, -1);
  endtask

  task automatic test_pause;
    run_instr(8'h17, 1'b0, 1'b0, 3, 4, -1);
  endtask

  task automatic test_reset_mid;
    run_instr(8'h3B, 1'b0, 1'b0, -1, 0, 4);
  endtask

  task automatic test_halt;
    run_instr(8'hF0, 1'b0, 1'b0, -1, 0, -1);
    for (int i = 0; i < 20; i++) begin
      run = 1'b1; bus_in = 8'($urandom); cf = 1'($urandom); zf = 1'($urandom);
      @(negedge clk);
      checks++;
      if (ctrl !== 13'h0 || t_state !== 3'd0 || halted !== 1'b1) begin
        errors++;
        $display("FAIL halted_idle: got ctrl %h t %0d h %b required 0000 0 1",
                 ctrl, t_state, halted);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_clear: got %b required 0", halted);
    end
    @(posedge clk); #1;
    run_instr(8'h00, 1'b0, 1'b0, -1, 0, -1);
  endtask

  task automatic test_random;
    logic [7:0] instr;
    int pa;
    for (int i = 0; i < 150; i++) begin
      instr = 8'($urandom_range(0, 8'hEF));
      pa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n_steps(instr[7:4]) - 1) : -1;
      run_instr(instr, 1'($urandom), 1'($urandom), pa, $urandom_range(1, 3), -1);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; bus_in = 8'h00; cf = 1'b0; zf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_nop;
    test_add_sub;
    test_jumps;
    test_pause;
    test_reset_mid;
    test_halt;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
